// File: rtl/regfile_write_scheduler_pkg.sv
// Shared constants and types for the register file write scheduler.
// The requester index map is fixed: ALU, then load, then debug.
package regfile_pkg;
    localparam int DEF_NUM_REQ = 3;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_DATA_W  = 32;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_DBG  = 2;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Writeback requester bundle between the writeback sources and the scheduler.
// The source data of requester i occupies slice [i*W +: W] of the packed buses.
interface regfile_write_scheduler_if
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
);
    // Handshake: requester i transfers when req_valid[i] && req_ready[i] at a
    // rising edge. It holds valid/rd/data stable until granted. req_ready is
    // one-hot or zero, is only set where req_valid is set, and depends only on
    // req_valid and the arbiter pointer.
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_rd;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (output req_valid, output req_rd, output req_data, input req_ready);
    modport slave  (input req_valid, input req_rd, input req_data, output req_ready);
endinterface

// File: rtl/regfile_write_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the priority pointer
// upwards with wrap; the pointer moves past the winner when advance is high.
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] idx;
    logic [PW-1:0] gidx;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        gidx  = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                gidx       = idx;
                found      = 1'b1;
            end
        end
        ptr_nxt = (int'(gidx) == N - 1) ? '0 : gidx + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= ptr_nxt;
        end
    end
endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates writeback requesters onto the single register file write port
// and tracks pending destinations so decode can stall on RAW hazards.
module regfile_write_scheduler
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    regfile_write_scheduler_if.slave wb,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_rd,
    input  logic [ADDR_W-1:0]        rs1,
    input  logic [ADDR_W-1:0]        rs2,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic                     hazard,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_rd,
    output logic [DATA_W-1:0]        rf_wdata
);
    localparam int NREG = 1 << ADDR_W;

    logic [NUM_REQ-1:0] grant;
    logic               advance;
    logic [ADDR_W-1:0]  sel_rd;
    logic [DATA_W-1:0]  sel_data;
    logic [NREG-1:0]    pend;
    logic [NREG-1:0]    pend_nxt;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (wb.req_valid),
        .advance (advance),
        .grant   (grant)
    );

    assign wb.req_ready = grant;
    assign advance      = |grant;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_rd   = wb.req_rd[i*ADDR_W +: ADDR_W];
                sel_data = wb.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A granted write to x0 is consumed but never reaches the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= advance && (sel_rd != '0);
            if (advance) begin
                rf_rd    <= sel_rd;
                rf_wdata <= sel_data;
            end
        end
    end

    // Set is applied after clear so a newer producer of the same register wins.
    always_comb begin
        pend_nxt = pend;
        if (rf_we) begin
            pend_nxt[rf_rd] = 1'b0;
        end
        if (issue_valid && issue_rd != '0) begin
            pend_nxt[issue_rd] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    assign rs1_busy = pend[rs1];
    assign rs2_busy = pend[rs2];
    assign hazard   = rs1_busy | rs2_busy;
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed and randomized bench for regfile_write_scheduler against a
// behavioural model of arbitration, write stage and pending scoreboard.
module tb_regfile_write_scheduler;
    import regfile_pkg::*;

    localparam int NR = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          rs1_busy;
    logic          rs2_busy;
    logic          hazard;
    logic          rf_we;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_wdata;

    regfile_write_scheduler_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) wb ();

    regfile_write_scheduler #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb          (wb),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .hazard      (hazard),
        .rf_we       (rf_we),
        .rf_rd       (rf_rd),
        .rf_wdata    (rf_wdata)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural reference state
    int            m_ptr;
    bit [31:0]     m_pend;
    bit            m_we;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] m_data;
    int            last_g;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (m_ptr + k) % NR;
            if (wb.req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_pend = '0;
        m_we   = 1'b0;
        m_rd   = '0;
        m_data = '0;
    endtask

    // Driver tasks
    task automatic clear_inputs();
        wb.req_valid = '0;
        wb.req_rd    = '0;
        wb.req_data  = '0;
        issue_valid  = 1'b0;
        issue_rd     = '0;
        rs1          = '0;
        rs2          = '0;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        wb.req_valid[i]         = 1'b1;
        wb.req_rd[i*AW +: AW]   = rd;
        wb.req_data[i*DW +: DW] = d;
    endtask

    // One clock: check combinational outputs, advance model at the edge,
    // check registered outputs, retire the granted requester and the issue.
    task automatic step();
        int            g;
        logic [AW-1:0] grd;
        logic [DW-1:0] gd;
        bit            iv;
        logic [AW-1:0] ird;
        logic [NR-1:0] exp_rdy;
        #1;
        g       = model_grant();
        exp_rdy = (g >= 0) ? NR'(1 << g) : '0;
        chk("req_ready", wb.req_ready, exp_rdy);
        chk("rs1_busy", rs1_busy, m_pend[rs1]);
        chk("rs2_busy", rs2_busy, m_pend[rs2]);
        chk("hazard", hazard, m_pend[rs1] | m_pend[rs2]);
        grd = '0;
        gd  = '0;
        if (g >= 0) begin
            grd = wb.req_rd[g*AW +: AW];
            gd  = wb.req_data[g*DW +: DW];
        end
        iv  = issue_valid;
        ird = issue_rd;
        @(posedge clk);
        if (m_we && m_rd != 0) m_pend[m_rd] = 1'b0;
        if (iv && ird != 0) m_pend[ird] = 1'b1;
        if (g >= 0) begin
            m_we   = (grd != 0);
            m_rd   = grd;
            m_data = gd;
            m_ptr  = (g + 1) % NR;
        end else begin
            m_we = 1'b0;
        end
        #1;
        chk("rf_we", rf_we, m_we);
        if (m_we) begin
            chk("rf_rd", rf_rd, m_rd);
            chk("rf_wdata", rf_wdata, m_data);
        end
        if (g >= 0) wb.req_valid[g] = 1'b0;
        issue_valid = 1'b0;
        last_g = g;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_ready", wb.req_ready, 0);
        chk("rst_hazard", hazard, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        last_g = -1;
        #2;
        do_reset();

        // Reset, then one ALU grant
        set_req(REQ_ALU, 5'd5, 32'hDEAD_BEEF);
        #1 chk("one_ready", wb.req_ready, 3'b001);
        step();
        chk("one_we", rf_we, 1);
        chk("one_rd", rf_rd, 5);
        chk("one_data", rf_wdata, 32'hDEAD_BEEF);
        step();
        chk("one_we_drop", rf_we, 0);

        // Round-robin rotation from a fresh pointer
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, AW'(i + 1), DW'(32'hA000 + i));
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rot_grant", last_g, k % NR);
            chk("rot_rd", rf_rd, k % NR + 1);
            set_req(last_g, AW'(last_g + 1), DW'(32'hA000 + last_g));
        end
        clear_inputs();
        step();

        // Scoreboard set then clear through the load port
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        rs1         = 5'd7;
        step();
        chk("sb_busy_set", rs1_busy, 1);
        set_req(REQ_LOAD, 5'd7, 32'h1234_5678);
        step();
        chk("sb_we", rf_we, 1);
        chk("sb_busy_hold", rs1_busy, 1);
        step();
        chk("sb_busy_clr", rs1_busy, 0);

        // Set wins over a same-cycle clear
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        rs1         = 5'd9;
        step();
        set_req(REQ_DBG, 5'd9, 32'h0000_0099);
        step();
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        step();
        chk("setwins_busy", rs1_busy, 1);

        // x0 handling
        set_req(REQ_DBG, 5'd0, 32'h0000_ABCD);
        #1 chk("x0_ready", wb.req_ready, 3'b100);
        step();
        chk("x0_we", rf_we, 0);
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        rs1         = 5'd0;
        rs2         = 5'd0;
        step();
        chk("x0_rs2_busy", rs2_busy, 0);
        chk("x0_hazard", hazard, 0);

        // Randomized traffic respecting the hold-until-granted rule
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!wb.req_valid[i] && $urandom_range(0, 1) == 1)
                    set_req(i, AW'($urandom_range(0, 7)), $urandom);
            end
            issue_valid = ($urandom_range(0, 9) < 3);
            issue_rd    = AW'($urandom_range(0, 7));
            rs1         = AW'($urandom_range(0, 7));
            rs2         = AW'($urandom_range(0, 7));
            step();
        end

        // Asynchronous reset in the middle of a write beat
        clear_inputs();
        step();
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        step();
        issue_valid = 1'b1;
        issue_rd    = 5'd4;
        step();
        set_req(REQ_ALU, 5'd6, 32'h0000_0066);
        step();
        chk("mid_pre_we", rf_we, 1);
        rs1 = 5'd3;
        rs2 = 5'd4;
        #1 chk("mid_pre_hazard", hazard, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rf_we", rf_we, 0);
        chk("mid_rf_rd", rf_rd, 0);
        chk("mid_rf_wdata", rf_wdata, 0);
        chk("mid_rs1_busy", rs1_busy, 0);
        chk("mid_hazard", hazard, 0);
        model_reset();
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        set_req(REQ_LOAD, 5'd10, 32'h0000_0110);
        set_req(REQ_DBG, 5'd11, 32'h0000_0111);
        #1 chk("post_rst_ready", wb.req_ready, 3'b010);
        step();
        step();
        chk("post_rst_second", last_g, REQ_DBG);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Schedules the register file's single write port among several writeback requesters, such as ALU, load unit and debug, using round-robin arbitration. It also keeps a pending-write scoreboard so decode can stall on read-after-write hazards. The block sits between the writeback sources and the register file write port (write enable, destination, data). It also sits beside decode, which issues destinations and queries source registers.

## Interface
Parameters:
- NUM_REQ, 3, number of writeback requesters; index 0 = ALU, 1 = load, 2 = debug.
- ADDR_W, 5, register address width (32 registers).
- DATA_W, 32, register data width.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester write request.
- req_rd  input  NUM_REQ*ADDR_W  destination register, packed; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  write data, packed the same way.
- req_ready  output  NUM_REQ  one-hot grant; combinational.
- issue_valid  input  1  decode has issued an instruction with a register destination.
- issue_rd  input  ADDR_W  destination of the issued instruction.
- rs1, rs2  input  ADDR_W  source registers being decoded.
- rs1_busy, rs2_busy  output  1  source has a pending write; combinational from scoreboard.
- hazard  output  1  rs1_busy | rs2_busy.
- rf_we  output  1  register file write enable; registered.
- rf_rd  output  ADDR_W  register file write destination; registered.
- rf_wdata  output  DATA_W  register file write data; registered.

## Operation
- **Handshake:** a transfer occurs on requester i when req_valid[i] && req_ready[i] at a rising edge.
  - A requester holds valid, rd and data stable until it is granted.
  - At most one grant per cycle.
  - req_ready[i] is asserted only when req_valid[i] is high.
- **Arbitration:** round-robin with a priority pointer ptr (0..NUM_REQ-1).
  - Search starts at ptr and wraps from NUM_REQ-1 to 0.
  - After a grant to index g, ptr becomes (g+1) mod NUM_REQ.
  - With no grant, ptr is unchanged.
- **Write stage:** an accepted request loads rf_rd/rf_wdata and sets rf_we=1 on the next cycle.
  - A cycle with no grant sets rf_we=0; rf_rd/rf_wdata hold their value.
- **x0 rules:**
  - A granted request with rd=0 is consumed (ready asserted) but produces rf_we=0.
  - issue_valid with issue_rd=0 sets nothing.
  - rs1=0 or rs2=0 never reports busy.
- **Scoreboard:** pend[31:1] bits; pend[0] is always 0.
  - Set: issue_valid && issue_rd!=0 sets pend[issue_rd].
  - Clear: rf_we=1 clears pend[rf_rd] at the edge where the register file commits the write.
  - Set and clear of the same register in the same cycle: set wins, because a newer producer is outstanding.
  - Writes to registers with pend=0 are legal (debug path); the clear is a no-op.
- **Busy query:** rsN_busy = pend[rsN]. There is no bypass of the rf_we cycle; decode stalls one extra cycle after the write.

## Timing
- **Reset (async assert):** rf_we=0, rf_rd=0, rf_wdata=0, pend=0, ptr=0.
  - Consequently req_ready is grant-only, and rs1_busy=rs2_busy=hazard=0.
  - Reset mid-transfer discards the in-flight rf_we beat and all pending bits.
- **Latency:**
  - Grant to rf_we high: 1 cycle.
  - Grant to register file contents updated: 2 edges.
  - Grant to pend cleared: 2 edges.
  - Issue to busy visible: 1 edge.
- **Throughput:** one write per cycle sustained. With all requesters valid, grants rotate 0,1,2,0,… with no idle cycle.
- **Fairness:** a continuously valid requester is granted within NUM_REQ cycles.
- req_ready depends only on req_valid and ptr. It has no combinational path from req_rd/req_data.

## Structure
- Shared package regfile_pkg holds:
  - ADDR_W, DATA_W and NUM_REQ defaults.
  - typedef reg_addr_t (logic [ADDR_W-1:0]).
  - typedef reg_data_t (logic [DATA_W-1:0]).
  - requester index localparams REQ_ALU=0, REQ_LOAD=1, REQ_DBG=2.
- One sub-module, rr_arbiter (parameter N), is natural. It contains the pointer register and one-hot grant logic, with inputs req and advance. The scoreboard and write stage stay in the top module.

## Test plan
- **Reset, then one grant:** ALU-only valid, rd=5, data=0xDEADBEEF → req_ready=001 same cycle; next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF; following cycle rf_we=0.
- **Round-robin rotation:** all three held valid for 6 cycles → grant sequence 0,1,2,0,1,2; rf_rd follows each requester's rd in that order.
- **Scoreboard set/clear:** issue rd=7 → rs1=7 busy next cycle; load granted rd=7 → rf_we at +1; rs1_busy drops after the commit edge (+2 from grant).
- **Set-wins collision:** pend[9]=1, and rf_we to rd=9 coincides with issue_valid rd=9 → pend[9] remains 1.
- **x0 handling:** debug writes rd=0 → req_ready=100, rf_we stays 0. issue rd=0 with rs2=0 → rs2_busy=0 and hazard=0.
- **Async reset mid-operation:** rst_n low while rf_we=1 and pend has several bits set → outputs 0 immediately; after release, ptr=0 and the first grant goes to the lowest valid index.
